hilo_div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider that produces the {HI, LO} write data for DIV/DIVU.
- EX stage starts it and stalls the pipeline until ready_o.
- result_o[63:32] (remainder) goes to the HI/LO write path as HI; result_o[31:0] (quotient) goes as LO.
- One division in flight; operands are latched at start.

---
 rtl/hilo_div_unit_pkg.sv | 24 ++
 rtl/hilo_div_unit_if.sv | 31 +++
 rtl/hilo_div_unit.sv | 132 +++++++++++++
 tb/tb_hilo_div_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hilo_div_unit_pkg.sv
// hilo_div_unit_pkg: shared state encoding and handshake constants for the HI/LO divider.
// Rev 1.0 - initial release.
`default_nettype none

package hilo_div_unit_pkg;

  localparam int DIV_DATA_W    = 32;
  localparam int DIV_DOUBLE_W  = 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

`default_nettype wire

// File: rtl/hilo_div_unit_if.sv
// hilo_div_unit_if: EX-stage request/result bundle for the divider.
// Rev 1.0 - initial release.
`default_nettype none

interface hilo_div_unit_if
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

`default_nettype wire

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle radix-2 restoring divider producing {remainder, quotient} for DIV/DIVU.
// Rev 1.0 - initial release.
`default_nettype none

module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  hilo_div_unit_if.slave   bus
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int WORK_W = 2 * DATA_W + 1;

  div_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [WORK_W-1:0]       work;
  logic [DATA_W-1:0]       divisor;
  logic                    neg_q;
  logic                    neg_r;
  logic [2*DATA_W-1:0]     result;
  logic                    ready;

  logic [DATA_W-1:0]       abs_op1;
  logic [DATA_W-1:0]       abs_op2;
  logic [DATA_W:0]         diff;
  logic [DATA_W-1:0]       quot_fix;
  logic [DATA_W-1:0]       rem_fix;
  logic                    accept;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  always_comb begin
    abs_op1 = bus.opdata1_i;
    abs_op2 = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) abs_op1 = negate(bus.opdata1_i);
    if (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) abs_op2 = negate(bus.opdata2_i);
  end

  // Partial remainder minus divisor; bit DATA_W set means the trial subtraction failed.
  always_comb begin
    diff     = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    quot_fix = neg_q ? negate(work[DATA_W-1:0]) : work[DATA_W-1:0];
    rem_fix  = neg_r ? negate(work[2*DATA_W:DATA_W+1]) : work[2*DATA_W:DATA_W+1];
    accept   = (bus.start_i == DIV_START) && !bus.annul_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result <= '0;
          ready  <= DIV_RESULT_NOT_READY;
          if (accept) begin
            if (bus.opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              // Dividend sits one bit up so the first trial compares its MSB.
              work    <= {{DATA_W{1'b0}}, abs_op1, 1'b0};
              divisor <= abs_op2;
              neg_q   <= bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
              neg_r   <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
            end
          end
        end

        DIV_BY_ZERO: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state  <= DIV_END;
            result <= '0;
            ready  <= DIV_RESULT_READY;
          end
        end

        DIV_ON: begin
          if (bus.annul_i) begin
            state  <= DIV_FREE;
            result <= '0;
            ready  <= DIV_RESULT_NOT_READY;
          end else if (cnt != CNT_W'(DATA_W)) begin
            if (diff[DATA_W]) begin
              work <= {work[2*DATA_W-1:0], 1'b0};
            end else begin
              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state  <= DIV_END;
            result <= {rem_fix, quot_fix};
            ready  <= DIV_RESULT_READY;
          end
        end

        DIV_END: begin
          if (bus.start_i == DIV_STOP) begin
            state  <= DIV_FREE;
            result <= '0;
            ready  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state <= DIV_FREE;
        end
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed and randomized checks of hilo_div_unit against an arithmetic model.
`default_nettype none

module tb_hilo_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hilo_div_unit_if #(.DATA_W(32)) bus ();

  hilo_div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: divide magnitudes with 64-bit arithmetic, then restore signs.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, q, r;
    logic nq, nr;
    if (b == 32'd0) return 64'd0;
    nq = sgn & (a[31] ^ b[31]);
    nr = sgn & a[31];
    ma = (sgn && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    mb = (sgn && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    q = ma / mb;
    r = ma % mb;
    if (nq) q = -q;
    if (nr) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges are counted including the accepting one: 34 for a normal divide
  // (33 after acceptance), 2 for divide-by-zero (IDLE->BYZERO->END).
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble, input int hold);
    int k;
    bit got;
    logic [63:0] exp;
    exp = model(sgn, a, b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    k   = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      tick();
      k++;
      if (scramble) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
      got = bus.ready_o;
    end
    check($sformatf("%s latency", tag), 64'(k), (b == 32'd0) ? 64'd2 : 64'd34);
    check($sformatf("%s result", tag), bus.result_o, exp);
    for (int h = 0; h < hold; h++) tick();
    if (hold > 0) begin
      check($sformatf("%s held", tag), {bus.result_o, 63'd0} | {63'd0, bus.ready_o}, {exp, 63'd0} | 64'd1);
    end
    bus.start_i = 1'b0;
    tick();
    check($sformatf("%s drop", tag), {bus.result_o[62:0], bus.ready_o}, 64'd0);
  endtask

  initial begin
    bit seen;
    logic sgn;
    logic [31:0] a, b;

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 1'b0, 0);
    check("divu 100/7 const", model(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("div -7/2 const", model(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run_div("div by zero", 1'b0, 32'h1234, 32'd0, 1'b0, 0);
    run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

    // Annul in IDLE suppresses acceptance.
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (3) tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= bus.ready_o;
    end
    check("idle annul no ready", 64'(seen), 64'd0);

    // Annul on the 10th ON cycle.
    bus.start_i = 1'b1;
    repeat (11) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = bus.ready_o;
    repeat (40) begin
      tick();
      seen |= bus.ready_o;
    end
    check("annul no ready", 64'(seen), 64'd0);
    check("annul result", bus.result_o, 64'd0);
    run_div("divu after annul", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, 0);

    // Reset mid-division on the 20th ON cycle.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (21) tick();
    rst = 1'b1;
    bus.start_i = 1'b0;
    tick();
    check("midrst outputs", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("midrst idle", 64'(bus.ready_o), 64'd0);
    run_div("after rst", 1'b0, 32'd1000, 32'd3, 1'b0, 0);

    run_div("latched ops", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b1, 5);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), sgn, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
